// File: rtl/regs_bank_msg.sv
// Register bank for the UPUM command interface: input, output and tristate GPIO channels
// with a one-hot message handshake (write echo, poll, auto-report on input change).
module regs_bank_msg #(
  parameter int unsigned          N_IN      = 4,
  parameter int unsigned          N_OUT     = 20,
  parameter int unsigned          N_IO      = 1,
  parameter logic [N_OUT*8-1:0]   OUT_RST   = '0,
  parameter logic [N_IN-1:0]      AUTO_MASK = '1,
  parameter int unsigned          ECHO      = 1,
  localparam int unsigned         N         = N_IN + N_OUT + 2 * N_IO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         master_data,
  input  logic [N-1:0]       valid_bus,
  input  logic [N-1:0]       rdreq_bus,
  output logic [N-1:0]       have_msg_bus,
  output logic [7:0]         len,
  output logic [7:0]         slave_data,
  input  logic [N_IN*8-1:0]  in_bus,
  output logic [N_OUT*8-1:0] out_bus,
  inout  wire  [N_IO*8-1:0]  gpio_io
);

  localparam int unsigned OutBase = N_IN;
  localparam int unsigned IovBase = N_IN + N_OUT;
  localparam int unsigned IozBase = N_IN + N_OUT + N_IO;

  logic [7:0] in_s1_q  [N_IN];
  logic [7:0] in_s2_q  [N_IN];
  logic [7:0] snap_q   [N_IN];
  logic [7:0] pad_s1_q [N_IO];
  logic [7:0] pad_s2_q [N_IO];
  logic [7:0] out_q    [N_OUT];
  logic [7:0] io_val_q [N_IO];
  logic [7:0] io_z_q   [N_IO];

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] set_req, auto_chg, ack;
  logic [7:0]   rb [N];

  assign len = 8'd1;

  // Two-flop synchronisers for input pins and pads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) begin
        in_s1_q[k] <= '0;
        in_s2_q[k] <= '0;
      end
      for (int g = 0; g < N_IO; g++) begin
        pad_s1_q[g] <= '0;
        pad_s2_q[g] <= '0;
      end
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        in_s1_q[k] <= in_bus[k*8 +: 8];
        in_s2_q[k] <= in_s1_q[k];
      end
      for (int g = 0; g < N_IO; g++) begin
        pad_s1_q[g] <= gpio_io[g*8 +: 8];
        pad_s2_q[g] <= pad_s1_q[g];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) out_q[j] <= OUT_RST[j*8 +: 8];
      for (int g = 0; g < N_IO; g++) begin
        io_val_q[g] <= '0;
        io_z_q[g]   <= 8'hFF;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (valid_bus[OutBase + j]) out_q[j] <= master_data;
      end
      for (int g = 0; g < N_IO; g++) begin
        if (valid_bus[IovBase + g]) io_val_q[g] <= master_data;
        if (valid_bus[IozBase + g]) io_z_q[g]   <= master_data;
      end
    end
  end

  // Snapshot holds the value last handed to the muxer, so auto-report fires only on change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) snap_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (ack[k]) snap_q[k] <= rb[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_IN; k++) rb[k] = in_s2_q[k];
    for (int j = 0; j < N_OUT; j++) rb[OutBase + j] = out_q[j];
    for (int g = 0; g < N_IO; g++) begin
      rb[IovBase + g] = pad_s2_q[g];
      rb[IozBase + g] = io_z_q[g];
    end
  end

  always_comb begin
    set_req  = '0;
    auto_chg = '0;
    for (int k = 0; k < N_IN; k++) begin
      set_req[k]  = valid_bus[k];
      auto_chg[k] = AUTO_MASK[k] && (in_s2_q[k] != snap_q[k]);
    end
    for (int j = 0; j < N_OUT; j++) begin
      set_req[OutBase + j] = valid_bus[OutBase + j] && (ECHO != 0);
    end
    for (int g = 0; g < N_IO; g++) begin
      set_req[IovBase + g] = valid_bus[IovBase + g];
      set_req[IozBase + g] = valid_bus[IozBase + g] && (ECHO != 0);
    end
  end

  always_comb begin
    have_msg_bus = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        have_msg_bus    = '0;
        have_msg_bus[i] = 1'b1;
      end
    end
  end

  assign ack = rdreq_bus & have_msg_bus;

  // A fresh write/poll beats the acknowledge; the acknowledge beats a stale auto-change
  assign pending_d = set_req | ((pending_q | auto_chg) & ~ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    slave_data = '0;
    for (int i = 0; i < N; i++) begin
      if (have_msg_bus[i]) slave_data = slave_data | rb[i];
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) out_bus[j*8 +: 8] = out_q[j];
  end

  for (genvar g = 0; g < N_IO; g++) begin : g_io
    for (genvar b = 0; b < 8; b++) begin : g_bit
      assign gpio_io[g*8 + b] = io_z_q[g][b] ? 1'bz : io_val_q[g][b];
    end
  end

endmodule

// File: tb/tb_regs_bank_msg.sv
// Directed bench for regs_bank_msg: reset, echo, auto-report, priority, GPIO and collisions.
module tb_regs_bank_msg;

  localparam int N = 26;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    master_data = '0;
  logic [N-1:0]  valid_bus = '0;
  logic [N-1:0]  rdreq_bus = '0;
  logic [N-1:0]  have_msg_bus;
  logic [7:0]    len;
  logic [7:0]    slave_data;
  logic [31:0]   in_bus = '0;
  logic [159:0]  out_bus;
  wire  [7:0]    gpio_io;
  logic [7:0]    tb_oe = '0;
  logic [7:0]    tb_val = '0;

  int n_cmp = 0;
  int n_err = 0;

  for (genvar b = 0; b < 8; b++) begin : g_pad
    assign gpio_io[b] = tb_oe[b] ? tb_val[b] : 1'bz;
  end

  regs_bank_msg #(
    .N_IN     (4),
    .N_OUT    (20),
    .N_IO     (1),
    .OUT_RST  ({{16{8'h00}}, 8'h5A, 8'h00, 8'h00, 8'hA5}),
    .AUTO_MASK(4'hF),
    .ECHO     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .master_data (master_data),
    .valid_bus   (valid_bus),
    .rdreq_bus   (rdreq_bus),
    .have_msg_bus(have_msg_bus),
    .len         (len),
    .slave_data  (slave_data),
    .in_bus      (in_bus),
    .out_bus     (out_bus),
    .gpio_io     (gpio_io)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_bus[7:0] !== 8'hA5) begin
      n_err++; $display("FAIL reset_out0: got %h want a5", out_bus[7:0]);
    end
    n_cmp++;
    if (out_bus[31:24] !== 8'h5A) begin
      n_err++; $display("FAIL reset_out3: got %h want 5a", out_bus[31:24]);
    end
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL reset_have_msg: got %h want 0", have_msg_bus);
    end
    n_cmp++;
    if (slave_data !== 8'h00) begin
      n_err++; $display("FAIL reset_slave_data: got %h want 00", slave_data);
    end
    n_cmp++;
    if (len !== 8'd1) begin
      n_err++; $display("FAIL reset_len: got %h want 01", len);
    end
    rst = 1'b0;
    // Pads must be released: an external pattern reads back through the value channel
    tb_oe = 8'hFF; tb_val = 8'h5A;
    repeat (2) @(negedge clk);
    valid_bus[24] = 1'b1; master_data = 8'h00;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 24) || slave_data !== 8'h5A) begin
      n_err++; $display("FAIL reset_pads_hiz: got %h/%h want %h/5a", have_msg_bus, slave_data,
                        26'd1 << 24);
    end
    rdreq_bus[24] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    tb_oe = 8'h00;
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL reset_pad_ack: got %h want 0", have_msg_bus);
    end
  endtask

  task automatic test_write_echo();
    valid_bus[7] = 1'b1; master_data = 8'h3C;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (out_bus[31:24] !== 8'h3C) begin
      n_err++; $display("FAIL echo_out_reg: got %h want 3c", out_bus[31:24]);
    end
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 7) || slave_data !== 8'h3C) begin
      n_err++; $display("FAIL echo_present: got %h/%h want %h/3c", have_msg_bus, slave_data,
                        26'd1 << 7);
    end
    rdreq_bus[7] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL echo_ack: got %h want 0", have_msg_bus);
    end
  endtask

  task automatic test_auto_report();
    in_bus[15:8] = 8'h05;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL auto_early: got %h want 0", have_msg_bus);
    end
    @(negedge clk);
    n_cmp++;
    if (have_msg_bus !== 26'd2 || slave_data !== 8'h05) begin
      n_err++; $display("FAIL auto_report: got %h/%h want 2/05", have_msg_bus, slave_data);
    end
    rdreq_bus[1] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL auto_ack: got %h want 0", have_msg_bus);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL auto_no_repeat: got %h want 0", have_msg_bus);
    end
    in_bus[15:8] = 8'h07;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (have_msg_bus !== 26'd2 || slave_data !== 8'h07) begin
      n_err++; $display("FAIL auto_change: got %h/%h want 2/07", have_msg_bus, slave_data);
    end
    rdreq_bus[1] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
  endtask

  task automatic test_priority();
    valid_bus[2] = 1'b1; valid_bus[10] = 1'b1; master_data = 8'h77;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 2) || slave_data !== 8'h00) begin
      n_err++; $display("FAIL prio_low_first: got %h/%h want 4/00", have_msg_bus, slave_data);
    end
    rdreq_bus[10] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 2)) begin
      n_err++; $display("FAIL prio_ignored_rdreq: got %h want 4", have_msg_bus);
    end
    rdreq_bus[2] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 10) || slave_data !== 8'h77) begin
      n_err++; $display("FAIL prio_next: got %h/%h want %h/77", have_msg_bus, slave_data,
                        26'd1 << 10);
    end
    rdreq_bus[10] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    n_cmp++;
    if (have_msg_bus !== 26'd0) begin
      n_err++; $display("FAIL prio_drain: got %h want 0", have_msg_bus);
    end
  endtask

  task automatic test_gpio();
    valid_bus[25] = 1'b1; master_data = 8'hF0;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 25) || slave_data !== 8'hF0) begin
      n_err++; $display("FAIL gpio_z_echo: got %h/%h want %h/f0", have_msg_bus, slave_data,
                        26'd1 << 25);
    end
    rdreq_bus[25] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    valid_bus[24] = 1'b1; master_data = 8'h0A;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (gpio_io[3:0] !== 4'b1010) begin
      n_err++; $display("FAIL gpio_drive: got %b want 1010", gpio_io[3:0]);
    end
    rdreq_bus[24] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
    tb_oe = 8'hF0; tb_val = 8'h80;
    repeat (3) @(negedge clk);
    valid_bus[24] = 1'b1; master_data = 8'h0A;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 24) || slave_data !== 8'h8A) begin
      n_err++; $display("FAIL gpio_poll: got %h/%h want %h/8a", have_msg_bus, slave_data,
                        26'd1 << 24);
    end
    rdreq_bus[24] = 1'b1;
    @(negedge clk);
    rdreq_bus = '0;
  endtask

  task automatic test_collision_reset();
    valid_bus[5] = 1'b1; master_data = 8'h11;
    @(negedge clk);
    valid_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 5) || slave_data !== 8'h11) begin
      n_err++; $display("FAIL coll_first: got %h/%h want 20/11", have_msg_bus, slave_data);
    end
    valid_bus[5] = 1'b1; rdreq_bus[5] = 1'b1; master_data = 8'h22;
    @(negedge clk);
    valid_bus = '0; rdreq_bus = '0;
    n_cmp++;
    if (have_msg_bus !== (26'd1 << 5) || slave_data !== 8'h22) begin
      n_err++; $display("FAIL coll_new_wins: got %h/%h want 20/22", have_msg_bus, slave_data);
    end
    n_cmp++;
    if (out_bus[15:8] !== 8'h22) begin
      n_err++; $display("FAIL coll_out_reg: got %h want 22", out_bus[15:8]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (have_msg_bus !== 26'd0 || slave_data !== 8'h00) begin
      n_err++; $display("FAIL rst_async_msg: got %h/%h want 0/00", have_msg_bus, slave_data);
    end
    n_cmp++;
    if (out_bus[15:8] !== 8'h00 || out_bus[7:0] !== 8'hA5) begin
      n_err++; $display("FAIL rst_async_regs: got %h/%h want 00/a5", out_bus[15:8],
                        out_bus[7:0]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_echo();
    test_auto_report();
    test_priority();
    test_gpio();
    test_collision_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
